io_hub_v2: RTL

Parametrised successor to the processor memory-mapped IO controller. Decodes the 8-bit IO address into block RAM, cell RAM, switches, LEDs, menu/touch, microphone and speaker. Adds a speaker sample FIFO, a mic capture latch with auto re-arm and overrun detection, and underrun counting. Sits between the processor datapath and the peripheral drivers.

---
 rtl/io_hub_v2.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/io_hub_v2.sv
// io_hub_v2: memory-mapped IO hub between the processor datapath and the
// peripheral drivers. Decodes the 8-bit IO address into block RAM, cell RAM,
// switches, LEDs, touch menu, microphone capture latch and speaker FIFO.
// Optional feature macro: IO_HUB_IRQ_EN adds the sticky irq status/enable
// registers at 0x44/0x45 and drives irq; without it irq is tied low.
//
// Mic handshake: mic_start is a level request; the first cycle with
// mic_done=1 while mic_start=1 is the capture. mic_start then drops and, in
// continuous mode, returns only after mic_done has been seen low and a
// two-cycle gap, so each sample sees a fresh low-to-high request edge.
module io_hub_v2 #(
   parameter int WIDTH      = 32,
   parameter int SPKR_DEPTH = 8,
   parameter int SAMPLE_W   = 16,
   parameter int MIC_W      = 12,
   parameter int LED_W      = 8,
   parameter int UCNT_W     = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          mem_addr,
   input  logic [WIDTH-1:0]    data_out1,
   input  logic                memwrite,
   input  logic                mem_en,
   input  logic [LED_W-1:0]    SW_I,
   output logic [LED_W-1:0]    LEDS,
   input  logic [1:0]          menu_in,
   input  logic [2:0]          filter,
   input  logic                mic_done,
   input  logic [MIC_W-1:0]    mic_data,
   output logic                mic_start,
   input  logic                spkr_update,
   output logic [SAMPLE_W-1:0] spkr_data,
   input  logic [WIDTH-1:0]    br_memdata_out,
   output logic [WIDTH-1:0]    br_memdata_in,
   output logic                br_memread,
   output logic                br_memwrite,
   input  logic [15:0]         cr_app_data_out,
   output logic [15:0]         cr_app_data_in,
   output logic                cr_memread,
   output logic                cr_memwrite,
   output logic                irq,
   output logic [WIDTH-1:0]    io_data
);

   localparam int AW = (SPKR_DEPTH > 1) ? $clog2(SPKR_DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {MIC_IDLE, MIC_ARMED, MIC_HOLD, MIC_GAP} mic_state_t;

   // Address decode
   logic rd_en, rd_mic;
   logic wr_led, wr_mic_ctrl, wr_push, wr_spkr_stat, wr_ucnt;
   assign rd_en        = mem_en & ~memwrite;
   assign rd_mic       = rd_en & (mem_addr == 8'h20);
   assign wr_led       = memwrite & (mem_addr == 8'h04);
   assign wr_mic_ctrl  = memwrite & (mem_addr == 8'h21);
   assign wr_push      = memwrite & (mem_addr == 8'h40);
   assign wr_spkr_stat = memwrite & (mem_addr == 8'h41);
   assign wr_ucnt      = memwrite & (mem_addr == 8'h42);

   assign br_memread  = (mem_addr == 8'h00) & mem_en;
   assign br_memwrite = (mem_addr == 8'h00) & memwrite;
   assign cr_memread  = mem_addr[7] & mem_en & ~memwrite;
   assign cr_memwrite = mem_addr[7] & memwrite;

   // Store data and LED registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         br_memdata_in  <= '0;
         cr_app_data_in <= '0;
         LEDS           <= '0;
      end else begin
         if (br_memwrite) br_memdata_in  <= data_out1;
         if (cr_memwrite) cr_app_data_in <= data_out1[15:0];
         if (wr_led)      LEDS           <= data_out1[LED_W-1:0];
      end
   end

   // Speaker FIFO control: pop on a rising spkr_update, pop before push
   logic [SAMPLE_W-1:0] fifo_mem [SPKR_DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [CW-1:0]       spkr_count, spkr_count_nxt;
   logic [UCNT_W-1:0]   ucnt;
   logic                upd_q, spkr_ovf;
   logic                pop_req, do_pop, do_push, underrun_ev, overflow_ev;
   logic                fifo_full, fifo_empty;

   assign fifo_full   = (spkr_count == CW'(SPKR_DEPTH));
   assign fifo_empty  = (spkr_count == '0);
   assign pop_req     = spkr_update & ~upd_q;
   assign do_pop      = pop_req & ~fifo_empty;
   assign do_push     = wr_push & (~fifo_full | do_pop);
   assign underrun_ev = pop_req & fifo_empty;
   assign overflow_ev = wr_push & fifo_full & ~do_pop;

   // Next occupancy, shared by the count register and the low-water detect
   always_comb begin
      spkr_count_nxt = spkr_count + CW'(do_push) - CW'(do_pop);
   end

   // FIFO storage, pointers, output sample, overflow flag and underrun count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SPKR_DEPTH; i++) fifo_mem[i] <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         spkr_count <= '0;
         spkr_data  <= '0;
         upd_q      <= 1'b0;
         spkr_ovf   <= 1'b0;
         ucnt       <= '0;
      end else begin
         upd_q      <= spkr_update;
         spkr_count <= spkr_count_nxt;
         if (do_push) begin
            fifo_mem[wr_ptr] <= data_out1[SAMPLE_W-1:0];
            wr_ptr           <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            spkr_data <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + AW'(1);
         end
         if (overflow_ev)                          spkr_ovf <= 1'b1;
         else if (wr_spkr_stat && data_out1[9])    spkr_ovf <= 1'b0;
         // a same-cycle underrun survives the clear
         if (wr_ucnt)                              ucnt <= underrun_ev ? UCNT_W'(1) : '0;
         else if (underrun_ev && (ucnt != '1))     ucnt <= ucnt + UCNT_W'(1);
      end
   end

   // Mic capture
   mic_state_t mic_state, mic_state_nxt;
   logic [MIC_W-1:0] mic_latch;
   logic             mic_valid, mic_ovr, mic_cont, capture;
   assign capture = mic_start & mic_done;

   // Mic FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) mic_state <= MIC_IDLE;
      else       mic_state <= mic_state_nxt;
   end

   // Mic FSM next state: arm write overrides everything
   always_comb begin
      mic_state_nxt = mic_state;
      case (mic_state)
         MIC_IDLE:  mic_state_nxt = MIC_IDLE;
         MIC_ARMED: if (mic_done) mic_state_nxt = mic_cont ? MIC_HOLD : MIC_IDLE;
         MIC_HOLD:  if (!mic_cont) mic_state_nxt = MIC_IDLE;
                    else if (!mic_done) mic_state_nxt = MIC_GAP;
         MIC_GAP:   mic_state_nxt = mic_cont ? MIC_ARMED : MIC_IDLE;
         default:   mic_state_nxt = MIC_IDLE;
      endcase
      if (wr_mic_ctrl && data_out1[0]) mic_state_nxt = MIC_ARMED;
   end

   // Mic FSM output: request is high only while armed
   always_comb begin
      mic_start = (mic_state == MIC_ARMED);
   end

   // Mic latch, valid/overrun flags and continuous-mode bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mic_latch <= '0;
         mic_valid <= 1'b0;
         mic_ovr   <= 1'b0;
         mic_cont  <= 1'b0;
      end else begin
         if (capture)     mic_latch <= mic_data;
         if (capture)     mic_valid <= 1'b1;
         else if (rd_mic) mic_valid <= 1'b0;
         if (capture && mic_valid)               mic_ovr <= 1'b1;
         else if (wr_mic_ctrl && data_out1[3])   mic_ovr <= 1'b0;
         if (wr_mic_ctrl) mic_cont <= data_out1[1];
      end
   end

   logic [2:0] irq_stat_v, irq_en_v;
`ifdef IO_HUB_IRQ_EN
   logic [2:0] irq_stat, irq_en, irq_ev;
   logic       irq_q, wr_irq_stat, wr_irq_en, spkr_low_ev;
   assign wr_irq_stat = memwrite & (mem_addr == 8'h44);
   assign wr_irq_en   = memwrite & (mem_addr == 8'h45);
   assign spkr_low_ev = (spkr_count > CW'(SPKR_DEPTH / 4)) &&
                        (spkr_count_nxt <= CW'(SPKR_DEPTH / 4));
   assign irq_ev      = {spkr_low_ev, capture & ~mic_valid, underrun_ev};

   // Sticky W1C status (set wins), enable register and registered irq
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_stat <= '0;
         irq_en   <= '0;
         irq_q    <= 1'b0;
      end else begin
         irq_stat <= irq_ev | (irq_stat & ~(wr_irq_stat ? data_out1[2:0] : 3'b000));
         if (wr_irq_en) irq_en <= data_out1[2:0];
         irq_q <= |(irq_stat & irq_en);
      end
   end
   assign irq        = irq_q;
   assign irq_stat_v = irq_stat;
   assign irq_en_v   = irq_en;
`else
   assign irq        = 1'b0;
   assign irq_stat_v = 3'b000;
   assign irq_en_v   = 3'b000;
`endif

   // Combinational load mux; zero whenever no load is in progress
   always_comb begin
      io_data = '0;
      if (rd_en) begin
         if (mem_addr[7]) io_data = WIDTH'(cr_app_data_out);
         else begin
            case (mem_addr)
               8'h00:   io_data = br_memdata_out;
               8'h02:   io_data = WIDTH'(SW_I);
               8'h04:   io_data = WIDTH'(LEDS);
               8'h08:   io_data = WIDTH'({filter, menu_in});
               8'h20:   io_data = WIDTH'({mic_latch, 4'b0000});
               8'h21:   io_data = WIDTH'({mic_ovr, mic_cont, mic_valid, mic_start});
               8'h41:   io_data = WIDTH'({spkr_ovf, fifo_full, fifo_empty, 7'(spkr_count)});
               8'h42:   io_data = WIDTH'(ucnt);
               8'h44:   io_data = WIDTH'(irq_stat_v);
               8'h45:   io_data = WIDTH'(irq_en_v);
               default: io_data = '0;
            endcase
         end
      end
   end

endmodule
